// File: rtl/lut_add_pipe.sv
// rtl/lut_add_pipe.sv - per-lane truth-table function summed with carry-in and accumulator, two-stage valid/ready pipeline
// Optional saturation of accumulate beats on carry: define LUT_ADD_SAT_EN.
module lut_add_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       tt,
  input  logic             cin,
  input  logic             acc_en,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             zero,
  output logic             ones,
  output logic             ovf
);

  logic             adv;
  logic [WIDTH-1:0] f_comb;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_f;
  logic             s1_cin;
  logic             s1_acc_en;
  logic             s1_clr;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  always_comb begin
    f_comb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f_comb[i] = tt[{a[i], b[i]}];
    end
  end

  always_comb begin
    opnd = (s1_acc_en && !s1_clr) ? acc : '0;
    sum  = {1'b0, s1_f} + {1'b0, opnd} + {{WIDTH{1'b0}}, s1_cin};
`ifdef LUT_ADD_SAT_EN
    res_next = (s1_acc_en && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    res_next = sum[WIDTH-1:0];
`endif
    // clr drops the old sticky state before this beat's own carry is folded in
    ovf_next = s1_clr ? 1'b0 : ovf;
    if (s1_acc_en && sum[WIDTH]) begin
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_f      <= '0;
      s1_cin    <= 1'b0;
      s1_acc_en <= 1'b0;
      s1_clr    <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_f      <= f_comb;
        s1_cin    <= cin;
        s1_acc_en <= acc_en;
        s1_clr    <= clr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      ones      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        res  <= res_next;
        cout <= sum[WIDTH];
        zero <= ~|res_next;
        ones <= &res_next;
        ovf  <= ovf_next;
        if (s1_acc_en) begin
          acc <= res_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_add_pipe.sv
// tb/tb_lut_add_pipe.sv - directed table, backpressure, reset and random scoreboard checks for lut_add_pipe
module tb_lut_add_pipe;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, acc_en, clr, out_valid, out_ready;
  logic [W-1:0] a, b, res;
  logic [3:0]   tt;
  logic         cout, zero, ones, ovf;

  lut_add_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .tt(tt), .cin(cin), .acc_en(acc_en), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .cout(cout),
    .zero(zero), .ones(ones), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         cout, zero, ones, ovf;
  } exp_t;

  typedef struct {
    logic [3:0]   tt;
    logic [W-1:0] a, b;
    logic         cin, acc_en, clr;
    exp_t         e;
  } vec_t;

  int   n_chk = 0, n_fail = 0;
  exp_t q[$];
  int   macc = 0;
  bit   movf = 0;
  bit   tbl_mode = 0, accepted = 0;
  exp_t cur_exp;
  int   rdy_mode = 0;   // 0 always ready, 1 stall cycles 2..4, 2 random, 3 never ready
  int   bp_cyc = 0, out_cnt = 0;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] t, input int av, input int bv,
                                 input bit c, input bit ae, input bit cl);
    exp_t e;
    int f = 0, s, op;
    for (int i = 0; i < W; i++) begin
      int idx = ((av >> i) & 1) * 2 + ((bv >> i) & 1);
      f += ((t >> idx) & 1) << i;
    end
    op = (ae && !cl) ? macc : 0;
    s  = f + op + int'(c);
    e.cout = (s >= (1 << W));
    s = s % (1 << W);
`ifdef LUT_ADD_SAT_EN
    if (ae && e.cout) s = (1 << W) - 1;
`endif
    e.res  = s[W-1:0];
    e.zero = (s == 0);
    e.ones = (s == (1 << W) - 1);
    if (cl) movf = 0;
    if (ae && e.cout) movf = 1;
    e.ovf = movf;
    if (ae) macc = s;
    return e;
  endfunction

  task automatic cycle();
    exp_t e, m;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = !(bp_cyc >= 2 && bp_cyc <= 4);
      2: out_ready = ($urandom_range(3) != 0);
      default: out_ready = 1'b0;
    endcase
    bp_cyc++;
    @(negedge clk);
    if (!rst) chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
    if (!rst && in_valid && in_ready) begin
      accepted = 1;
      m = model(tt, int'(a), int'(b), cin, acc_en, clr);
      q.push_back(tbl_mode ? cur_exp : m);
    end
    if (!rst && out_valid && out_ready) begin
      out_cnt++;
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("res", res, e.res);
        chk("cout", cout, e.cout);
        chk("zero", zero, e.zero);
        chk("ones", ones, e.ones);
        chk("ovf", ovf, e.ovf);
      end
    end
    if (rst) begin
      q.delete();
      macc = 0;
      movf = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] t, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic c, input logic ae, input logic cl);
    tt = t; a = av; b = bv; cin = c; acc_en = ae; clr = cl;
    in_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 50 && !accepted; i++) cycle();
    if (!accepted) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) cycle();
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic exp_t mk(input int r, input bit co, input bit z, input bit o, input bit v);
    exp_t e;
    e.res = r[W-1:0]; e.cout = co; e.zero = z; e.ones = o; e.ovf = v;
    return e;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; tt = '0; cin = 0; acc_en = 0; clr = 0;

    tbl[0] = '{4'b0110, 4'b0101, 4'b0011, 0, 0, 0, mk(6, 0, 0, 0, 0)};
    tbl[1] = '{4'b1111, 4'b0000, 4'b0000, 1, 0, 0, mk(0, 1, 1, 0, 0)};
    tbl[2] = '{4'b0000, 4'b0000, 4'b0000, 0, 1, 0, mk(0, 0, 1, 0, 0)};
    tbl[3] = '{4'b1100, 4'b1001, 4'b0000, 0, 1, 0, mk(9, 0, 0, 0, 0)};
`ifdef LUT_ADD_SAT_EN
    tbl[4] = '{4'b1100, 4'b1001, 4'b0000, 0, 1, 0, mk(15, 1, 0, 1, 1)};
    tbl[5] = '{4'b1100, 4'b1001, 4'b0000, 0, 1, 0, mk(15, 1, 0, 1, 1)};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 0, 1, 0, mk(15, 0, 0, 1, 0)};
`else
    tbl[4] = '{4'b1100, 4'b1001, 4'b0000, 0, 1, 0, mk(2, 1, 0, 0, 1)};
    tbl[5] = '{4'b1100, 4'b1001, 4'b0000, 0, 1, 0, mk(11, 0, 0, 0, 1)};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 0, 1, 0, mk(11, 0, 0, 0, 0)};
`endif
    // clr without acc_en: sticky flag drops, accumulator kept
    tbl[6] = '{4'b1111, 4'b0000, 4'b0000, 0, 0, 1, mk(15, 0, 0, 1, 0)};
    tbl[8] = '{4'b1100, 4'b0011, 4'b0000, 0, 1, 1, mk(3, 0, 0, 0, 0)};
    tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 0, 1, 0, mk(3, 0, 0, 0, 0)};

    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_zero", zero, 0);
    chk("rst_res", res, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);

    tbl_mode = 1;
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) begin
      cur_exp = tbl[i].e;
      send(tbl[i].tt, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].acc_en, tbl[i].clr);
    end
    drain();
    tbl_mode = 0;

    // latency of a lone beat
    send(4'b0110, 4'b1010, 4'b0110, 0, 0, 0);
    chk("lat_after_accept", out_valid, 0);
    cycle();
    chk("lat_next_edge", out_valid, 1);
    drain();

    // backpressure: five back-to-back distinct beats
    out_cnt = 0;
    bp_cyc = 0;
    rdy_mode = 1;
    for (int i = 1; i <= 5; i++) send(4'b1100, i[W-1:0], 4'b0000, 0, 0, 0);
    rdy_mode = 0;
    drain();
    chk("bp_out_count", out_cnt, 5);

    // reset with two beats in flight and ovf set
    send(4'b1100, 4'b1111, 4'b0000, 0, 1, 0);
    drain();
    chk("pre_rst_ovf", ovf, 1);
    rdy_mode = 3;
    send(4'b1100, 4'b0101, 4'b0000, 0, 1, 0);
    send(4'b1100, 4'b0110, 4'b0000, 0, 1, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_ovf", ovf, 0);
    rdy_mode = 0;
    send(4'b0000, 4'b0000, 4'b0000, 0, 1, 0);
    drain();
    chk("post_rst_acc_zero", res, 0);

    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      int gap = $urandom_range(2);
      for (int g = 0; g < gap; g++) cycle();
      send($urandom_range(15), $urandom_range(15), $urandom_range(15),
           $urandom_range(1), $urandom_range(1), ($urandom_range(7) == 0));
    end
    rdy_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
